// File: rtl/sfr_master_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | sfr_arb_pkg : shared types and helpers for the SFR master arbiter        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef SFR_ADDR_WIDTH
`define SFR_ADDR_WIDTH 8
`endif
`ifndef SFR_DATA_WIDTH
`define SFR_DATA_WIDTH 8
`endif
`ifndef SFR_PAGE_NUM
`define SFR_PAGE_NUM 4
`endif

package sfr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Returned as read data when an access times out; sliced to DATA_WIDTH.
  localparam logic [63:0] ERR_DATA = '1;

  function automatic int calc_page_w(input int page_num);
    return (page_num > 1) ? $clog2(page_num) : 1;
  endfunction

  function automatic int calc_cnt_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfr_master_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | sfr_if   : SFR bus between the master arbiter and the decode fabric      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef SFR_ADDR_WIDTH
`define SFR_ADDR_WIDTH 8
`endif
`ifndef SFR_DATA_WIDTH
`define SFR_DATA_WIDTH 8
`endif
`ifndef SFR_PAGE_NUM
`define SFR_PAGE_NUM 4
`endif

interface sfr_if
  import sfr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = `SFR_ADDR_WIDTH,
  parameter int DATA_WIDTH = `SFR_DATA_WIDTH,
  parameter int PAGE_W     = calc_page_w(`SFR_PAGE_NUM)
);

  logic [ADDR_WIDTH-1:0] sfraddr;
  logic                  sfrwe;
  logic                  sfroe;
  logic [DATA_WIDTH-1:0] sfrdatao;
  logic [DATA_WIDTH-1:0] sfrdatai;
  logic                  sfrack;
  logic [PAGE_W-1:0]     sfr_page_sel;

  modport master (
    output sfraddr, sfrwe, sfroe, sfrdatao, sfr_page_sel,
    input  sfrdatai, sfrack
  );

  modport slave (
    input  sfraddr, sfrwe, sfroe, sfrdatao, sfr_page_sel,
    output sfrdatai, sfrack
  );

endinterface

`default_nettype wire

// File: rtl/sfr_master_arbiter_rr.sv
// +--------------------------------------------------------------------------+
// | sfr_rr_arbiter : round-robin pick with registered rotating pointer       |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module sfr_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;

  // Rotate so bit 0 is the requester at the pointer; the lowest set bit wins.
  assign w_rot = NUM_REQ'({req, req} >> r_ptr);

  always_comb begin
    w_off = '0;
    any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IDX_W'(k);
        any   = 1'b1;
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
      w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
    end
  end

  assign idx    = w_sum[IDX_W-1:0];
  assign winner = any ? (NUM_REQ'(1) << idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (grant_en && any) begin
      r_ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sfr_master_arbiter.sv
// +--------------------------------------------------------------------------+
// | sfr_master_arbiter : round-robin share of one SFR master port, timeout   |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef SFR_ADDR_WIDTH
`define SFR_ADDR_WIDTH 8
`endif
`ifndef SFR_DATA_WIDTH
`define SFR_DATA_WIDTH 8
`endif
`ifndef SFR_PAGE_NUM
`define SFR_PAGE_NUM 4
`endif

module sfr_master_arbiter
  import sfr_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = `SFR_ADDR_WIDTH,
  parameter  int DATA_WIDTH = `SFR_DATA_WIDTH,
  parameter  int PAGE_NUM   = `SFR_PAGE_NUM,
  parameter  int TIMEOUT    = 16,
  localparam int PAGE_W     = calc_page_w(PAGE_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*PAGE_W-1:0]     req_page,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          busy,
  sfr_if.master                         sfr
);

  localparam int               CNT_W    = calc_cnt_w(TIMEOUT);
  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [PAGE_W-1:0]     r_page;
  logic [NUM_REQ-1:0]    r_owner;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_busy;
  logic                  r_sfrwe;
  logic                  r_sfroe;

  logic [NUM_REQ-1:0]    w_winner;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [PAGE_W-1:0]     w_sel_page;

  sfr_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant_en (r_state == IDLE),
    .winner   (w_winner),
    .idx      (w_idx),
    .any      (w_any)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_page  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_page  = req_page[i*PAGE_W +: PAGE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_page  <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_sfrwe <= 1'b0;
      r_sfroe <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_page  <= w_sel_page;
            r_owner <= w_winner;
            r_gnt   <= w_winner;
            r_sfrwe <= w_sel_we;
            r_sfroe <= !w_sel_we;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack in the final wait cycle takes priority over the timeout.
          if (sfr.sfrack) begin
            r_rdata <= r_we ? '0 : sfr.sfrdatai;
            r_err   <= 1'b0;
            r_gnt   <= '0;
            r_sfrwe <= 1'b0;
            r_sfroe <= 1'b0;
            r_done  <= r_owner;
            r_state <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata <= ERR_DATA[DATA_WIDTH-1:0];
            r_err   <= 1'b1;
            r_gnt   <= '0;
            r_sfrwe <= 1'b0;
            r_sfroe <= 1'b0;
            r_done  <= r_owner;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign err   = r_err;
  assign busy  = r_busy;

  assign sfr.sfraddr      = r_addr;
  assign sfr.sfrdatao     = r_wdata;
  assign sfr.sfr_page_sel = r_page;
  assign sfr.sfrwe        = r_sfrwe;
  assign sfr.sfroe        = r_sfroe;

endmodule

`default_nettype wire

// File: tb/tb_sfr_master_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_sfr_master_arbiter : randomized self-checking bench, transaction model|
// | Revision              : 1.0                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sfr_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int PW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*PW-1:0] req_page;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            busy;

  sfr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PAGE_W(PW)) bus ();

  sfr_master_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PAGE_NUM   (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_page  (req_page),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .sfr       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  logic [N-1:0]  f_we;
  logic [AW-1:0] f_addr  [N];
  logic [DW-1:0] f_wdata [N];
  logic [PW-1:0] f_page  [N];

  task automatic pack_fields();
    req_we = f_we;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = f_addr[i];
      req_wdata[i*DW +: DW] = f_wdata[i];
      req_page[i*PW +: PW]  = f_page[i];
    end
  endtask

  task automatic rand_fields();
    f_we = N'($urandom);
    for (int i = 0; i < N; i++) begin
      f_addr[i]  = AW'($urandom);
      f_wdata[i] = DW'($urandom);
      f_page[i]  = PW'($urandom_range(0, 3));
    end
    pack_fields();
  endtask

  // Round-robin reference: first requester at or after the pointer.
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(model_ptr + k) % N]) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge idle.
  // ack_at: ACCESS cycle (1-based) carrying sfrack, outside 1..TO means never.
  task automatic run_txn(input logic [N-1:0] mask, input int ack_at,
                         input int ack_data, input string name);
    int            w;
    int            last;
    logic [N-1:0]  e_gnt;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [PW-1:0] e_page;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    logic [DW-1:0] din;
    w       = pick(mask);
    e_gnt   = '0;
    e_gnt[w] = 1'b1;
    e_we    = f_we[w];
    e_addr  = f_addr[w];
    e_wdata = f_wdata[w];
    e_page  = f_page[w];
    model_ptr = (w + 1) % N;
    e_err   = !(ack_at >= 1 && ack_at <= TO);
    last    = e_err ? TO : ack_at;
    e_rdata = e_err ? {DW{1'b1}} : '0;
    pack_fields();
    req = mask;
    bus.sfrack = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt, bus.sfrwe, bus.sfroe, bus.sfraddr, bus.sfrdatao, bus.sfr_page_sel, done, busy} !==
          {e_gnt, e_we, !e_we, e_addr, e_wdata, e_page, {N{1'b0}}, 1'b1}) begin
        errors++;
        $display("FAIL %s access cycle %0d: got gnt=%b we=%b oe=%b addr=%h wd=%h pg=%0d done=%b busy=%b, want gnt=%b we=%b oe=%b addr=%h wd=%h pg=%0d done=0 busy=1",
                 name, c, gnt, bus.sfrwe, bus.sfroe, bus.sfraddr, bus.sfrdatao, bus.sfr_page_sel, done, busy,
                 e_gnt, e_we, !e_we, e_addr, e_wdata, e_page);
      end
      if (c == 1) rand_fields();
      din = (ack_data < 0) ? DW'($urandom) : DW'(ack_data);
      bus.sfrdatai = din;
      bus.sfrack   = (c == ack_at);
      if (c == ack_at) e_rdata = e_we ? '0 : din;
    end
    @(negedge clk);
    checks++;
    if ({done, gnt, bus.sfrwe, bus.sfroe, bus.sfraddr, bus.sfr_page_sel, rdata, err, busy} !==
        {e_gnt, {N{1'b0}}, 1'b0, 1'b0, e_addr, e_page, e_rdata, e_err, 1'b1}) begin
      errors++;
      $display("FAIL %s resp: got done=%b gnt=%b we=%b oe=%b addr=%h pg=%0d rdata=%h err=%b busy=%b, want done=%b gnt=0 we=0 oe=0 addr=%h pg=%0d rdata=%h err=%b busy=1",
               name, done, gnt, bus.sfrwe, bus.sfroe, bus.sfraddr, bus.sfr_page_sel, rdata, err, busy,
               e_gnt, e_addr, e_page, e_rdata, e_err);
    end
    req = '0;
    bus.sfrack = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, gnt, busy, bus.sfrwe, bus.sfroe, rdata, err, bus.sfr_page_sel} !==
        {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, 1'b0, e_rdata, e_err, e_page}) begin
      errors++;
      $display("FAIL %s idle: got done=%b gnt=%b busy=%b we=%b oe=%b rdata=%h err=%b pg=%0d, want done=0 gnt=0 busy=0 rdata=%h err=%b pg=%0d",
               name, done, gnt, busy, bus.sfrwe, bus.sfroe, rdata, err, bus.sfr_page_sel,
               e_rdata, e_err, e_page);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    bus.sfrack = 1'b0;
    bus.sfrdatai = '0;
    rand_fields();
    @(negedge clk);
    checks++;
    if ({gnt, done, rdata, err, busy, bus.sfraddr, bus.sfrwe, bus.sfroe, bus.sfrdatao, bus.sfr_page_sel} !== '0) begin
      errors++;
      $display("FAIL reset: got gnt=%b done=%b rdata=%h err=%b busy=%b addr=%h we=%b oe=%b wd=%h pg=%0d, want all 0",
               gnt, done, rdata, err, busy, bus.sfraddr, bus.sfrwe, bus.sfroe, bus.sfrdatao, bus.sfr_page_sel);
    end
    rst = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_directed();
    f_we[0] = 1'b1; f_addr[0] = 8'h12; f_wdata[0] = 8'hA5; f_page[0] = 2'd2;
    run_txn(4'b0001, 2, -1, "write0");
    f_we[2] = 1'b0;
    run_txn(4'b0100, 1, 8'h3C, "read2");
  endtask

  task automatic test_timeout();
    rand_fields();
    f_we[1] = 1'b0;
    run_txn(4'b0010, 0, -1, "timeout");
    rand_fields();
    run_txn(4'b0100, 1, -1, "after_timeout");
    rand_fields();
    f_we[3] = 1'b0;
    run_txn(4'b1000, TO, -1, "ack_at_limit");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] m;
      int a;
      rand_fields();
      m = N'($urandom_range(1, 15));
      a = $urandom_range(1, 20);
      run_txn(m, a, -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e_g;
    logic [N-1:0] e_d;
    test_reset();
    rand_fields();
    req = 4'b1111;
    bus.sfrack = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      e_g = '0;
      e_d = '0;
      if (n % 3 == 1) e_g[((n - 1) / 3) % N] = 1'b1;
      if (n % 3 == 2) e_d[((n - 1) / 3) % N] = 1'b1;
      checks++;
      if ({gnt, done} !== {e_g, e_d}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got gnt=%b done=%b, want gnt=%b done=%b",
                 n, gnt, done, e_g, e_d);
      end
      bus.sfrdatai = DW'($urandom);
    end
    req = '0;
    bus.sfrack = 1'b0;
    model_ptr = 5 % N;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    rand_fields();
    req = 4'b0001;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, done, rdata, err, busy, bus.sfraddr, bus.sfrwe, bus.sfroe, bus.sfrdatao, bus.sfr_page_sel} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got gnt=%b done=%b rdata=%h err=%b busy=%b addr=%h we=%b oe=%b wd=%h pg=%0d, want all 0",
               gnt, done, rdata, err, busy, bus.sfraddr, bus.sfrwe, bus.sfroe, bus.sfrdatao, bus.sfr_page_sel);
    end
    @(negedge clk);
    rst = 1'b1;
    model_ptr = 0;
    rand_fields();
    run_txn(4'b1010, 1, -1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sfr_master_arbiter.md
Name: sfr_master_arbiter

Overview:
- Shares one SFR master port between NUM_REQ internal requesters, for example a config sequencer, a debug bridge and firmware-assist engines.
- Arbitration is round-robin. The block runs one read or write transaction at a time on the SFR bus and drives sfr_page_sel for each access.
- Each access completes on sfrack or ends with an error after a bounded number of wait cycles.
- Sits directly in front of the SFR decode fabric. Its SFR-side ports connect straight to an sfr_if instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, `SFR_ADDR_WIDTH, SFR address width
- DATA_WIDTH, `SFR_DATA_WIDTH, SFR data width
- PAGE_NUM, `SFR_PAGE_NUM, number of SFR pages; PAGE_W = $clog2(PAGE_NUM)
- TIMEOUT, 16, maximum cycles in ACCESS waiting for sfrack (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request, held until its done pulse
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, slice i for requester i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_page  in  NUM_REQ*PAGE_W  packed page numbers
- gnt  out  NUM_REQ  one-hot, high for the whole transaction of the owner
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- rdata  out  DATA_WIDTH  read data, valid while done is high
- err  out  1  timeout flag, valid while done is high
- busy  out  1  high in any state other than IDLE
- sfraddr  out  ADDR_WIDTH  SFR address
- sfrwe  out  1  write strobe
- sfroe  out  1  read strobe
- sfrdatao  out  DATA_WIDTH  write data
- sfrdatai  in  DATA_WIDTH  read data from the fabric
- sfrack  in  1  access acknowledge
- sfr_page_sel  out  PAGE_W  page select

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs are 0, including sfr_page_sel;
  - state is IDLE;
  - round-robin pointer is 0;
  - timeout counter is 0.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any req bit is set, pick the first set bit starting at the pointer index, wrapping modulo NUM_REQ.
  - On that edge, latch the winner's we, addr, wdata and page into internal registers and set gnt[winner].
  - Set pointer = (winner+1) mod NUM_REQ, clear the counter, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - sfraddr, sfrdatao and sfr_page_sel come from the latched registers.
  - sfrwe = latched we; sfroe = !latched we. Exactly one strobe is high.
  - Strobes and gnt assert in the first ACCESS cycle, one cycle after req is sampled.
  - If sfrack=1, capture sfrdatai (reads only; writes give rdata=0), set err=0 and go to RESP.
  - Otherwise, if counter==TIMEOUT-1, set rdata to all ones, err=1 and go to RESP.
  - Otherwise, counter++.
  - If sfrack and the timeout arrive in the same cycle, the ack wins (err=0).
- RESP:
  - done[owner]=1 for exactly one cycle; rdata and err are valid.
  - sfrwe, sfroe and gnt are 0.
  - sfraddr, sfrdatao and sfr_page_sel hold their values.
  - Next state is IDLE.
- Throughput: minimum of 3 cycles per transaction (ACCESS with immediate ack, RESP, IDLE arbitration).
- sfr_page_sel is sticky: it keeps the last transaction's page until the next grant.
- sfrack outside ACCESS is ignored.
- A req dropped before grant is ignored.
- A req dropped after grant does not abort the transaction; done still pulses.
- Requester fields are sampled only at grant. Later changes have no effect.
- A requester that holds req through its done pulse is treated as a new request on the next IDLE cycle. It then competes under round-robin order.
- gnt is one-hot or zero. done is one-hot or zero.
- rdata and err hold their values after RESP until the next RESP.
- Counter width is $clog2(TIMEOUT). It saturates and cannot wrap.

Decomposition:
- Package sfr_arb_pkg contains:
  - state enum (IDLE, ACCESS, RESP);
  - PAGE_W and counter-width helper functions;
  - the error-data constant (all ones).
- Sub-module sfr_rr_arbiter provides round-robin selection:
  - combinational pick: inputs req and pointer, outputs one-hot winner plus index;
  - registered pointer update when grant_en is high.
- The FSM, latches and timeout logic stay in the top module.

Test Plan:
- Reset, then req=4'b0001 write with addr=0x12, wdata=0xA5, page=2, and sfrack one cycle later:
  - sfrwe=1, sfraddr=0x12 and sfr_page_sel=2 for 2 cycles;
  - then done[0]=1 for one cycle with err=0.
- Read from requester 2 with the fabric returning sfrdatai=0x3C alongside sfrack: done[2] is high with rdata=0x3C and sfroe is low in that cycle.
- req=4'b1111 held permanently with immediate acks: grant order is 0,1,2,3,0; each done is one cycle; transactions start every 3 cycles.
- sfrack never asserted, TIMEOUT=16: ACCESS lasts exactly 16 cycles, then done with err=1 and rdata=0xFF (DATA_WIDTH=8); the next request is served normally.
- sfrack asserted in the 16th ACCESS cycle: err=0 and the ack wins.
- rst driven low mid-ACCESS: all outputs go to 0 immediately; after release the pointer is 0, so req=4'b1010 grants requester 1 first.
